// File: rtl/clint_trap_ctrl.sv
// clint_trap_ctrl: trap and interrupt sequencer for the machine-mode CSR file.
// It takes a machine-timer interrupt or an ecall, writes mepc, mcause and mstatus
// through the clint write port one CSR per cycle, and then redirects the PC to the
// handler. On mret it restores mstatus and redirects the PC to mepc.
// The pipeline is stalled from the accept cycle until the redirect cycle.
// A CPU CSR write takes priority at the CSR file, so a pending clint write waits
// until the CPU port is free.
module clint_trap_ctrl #(
  parameter int unsigned ECALL_CAUSE = 11,
  parameter int unsigned MTI_CAUSE   = 7,
  parameter bit          VECTOR_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [63:0] inst_pc_i,
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic        cpu_csr_wen_i,
  input  logic [63:0] csr_mtvec_i,
  input  logic [63:0] csr_mepc_i,
  input  logic [63:0] csr_mstatus_i,
  input  logic        global_int_en_i,
  input  logic        mtime_int_en_i,
  input  logic        mtime_int_pend_i,
  output logic        clint_csr_wen_o,
  output logic [11:0] clint_csr_waddr_o,
  output logic [63:0] clint_csr_wdata_o,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [63:0] redirect_pc_o
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  // Interrupt causes carry the interrupt flag in bit 63; exceptions leave it clear.
  localparam logic [63:0] INT_CAUSE_W   = {1'b1, 63'(MTI_CAUSE)};
  localparam logic [63:0] ECALL_CAUSE_W = 64'(ECALL_CAUSE);
  localparam logic [63:0] VEC_OFFSET    = 64'(MTI_CAUSE) << 2;

  typedef enum logic [2:0] {
    IDLE,
    WR_MEPC,
    WR_MCAUSE,
    WR_MSTATUS,
    WR_MSTATUS_RET,
    REDIRECT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic        int_evt;
  logic        take_int;
  logic        take_ecall;
  logic        take_mret;
  logic        accept;

  logic [63:0] pc_q;
  logic [63:0] mstatus_q;
  logic [63:0] mtvec_q;
  logic [63:0] mepc_q;
  logic [63:0] cause_q;
  logic        is_int_q;
  logic        is_mret_q;

  logic [63:0] trap_mstatus;
  logic [63:0] ret_mstatus;
  logic [63:0] trap_target;
  logic [63:0] trap_base;

  // Prioritised event decode: timer interrupt first, then ecall, then mret.
  always_comb begin
    int_evt    = global_int_en_i & mtime_int_en_i & mtime_int_pend_i;
    take_int   = inst_valid_i & int_evt;
    take_ecall = inst_valid_i & ecall_i & ~int_evt;
    take_mret  = inst_valid_i & mret_i & ~int_evt & ~ecall_i;
    accept     = (state_q == IDLE) & ~rst & (take_int | take_ecall | take_mret);
  end

  // Snapshot the instruction and CSR context at accept so later CSR writes cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      mstatus_q <= '0;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      cause_q   <= '0;
      is_int_q  <= 1'b0;
      is_mret_q <= 1'b0;
    end else if (accept) begin
      pc_q      <= inst_pc_i;
      mstatus_q <= csr_mstatus_i;
      mtvec_q   <= csr_mtvec_i;
      mepc_q    <= csr_mepc_i;
      is_int_q  <= take_int;
      is_mret_q <= take_mret;
      if (take_int) begin
        cause_q <= INT_CAUSE_W;
      end else if (take_ecall) begin
        cause_q <= ECALL_CAUSE_W;
      end else begin
        cause_q <= '0;
      end
    end
  end

  // mstatus images for trap entry (stack MIE into MPIE) and mret (pop MPIE into MIE).
  always_comb begin
    trap_mstatus        = mstatus_q;
    trap_mstatus[7]     = mstatus_q[3];
    trap_mstatus[3]     = 1'b0;
    trap_mstatus[12:11] = 2'b11;

    ret_mstatus         = mstatus_q;
    ret_mstatus[3]      = mstatus_q[7];
    ret_mstatus[7]      = 1'b1;
    ret_mstatus[12:11]  = 2'b11;
  end

  // Handler address; vectored mode only applies to interrupts, exceptions use the base.
  always_comb begin
    trap_base   = {mtvec_q[63:2], 2'b00};
    trap_target = trap_base;
    if (VECTOR_EN && is_int_q && (mtvec_q[1:0] == 2'b01)) begin
      trap_target = trap_base + VEC_OFFSET;
    end
  end

  // State register; reset aborts any sequence in flight without issuing a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and outputs; write states retry in place while the CPU owns the CSR port.
  always_comb begin
    state_d           = state_q;
    clint_csr_wen_o   = 1'b0;
    clint_csr_waddr_o = '0;
    clint_csr_wdata_o = '0;
    stall_o           = 1'b0;
    redirect_valid_o  = 1'b0;
    redirect_pc_o     = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          state_d = take_mret ? WR_MSTATUS_RET : WR_MEPC;
        end
      end

      WR_MEPC: begin
        stall_o           = 1'b1;
        clint_csr_wen_o   = ~cpu_csr_wen_i;
        clint_csr_waddr_o = ADDR_MEPC;
        clint_csr_wdata_o = pc_q;
        if (!cpu_csr_wen_i) begin
          state_d = WR_MCAUSE;
        end
      end

      WR_MCAUSE: begin
        stall_o           = 1'b1;
        clint_csr_wen_o   = ~cpu_csr_wen_i;
        clint_csr_waddr_o = ADDR_MCAUSE;
        clint_csr_wdata_o = cause_q;
        if (!cpu_csr_wen_i) begin
          state_d = WR_MSTATUS;
        end
      end

      WR_MSTATUS: begin
        stall_o           = 1'b1;
        clint_csr_wen_o   = ~cpu_csr_wen_i;
        clint_csr_waddr_o = ADDR_MSTATUS;
        clint_csr_wdata_o = trap_mstatus;
        if (!cpu_csr_wen_i) begin
          state_d = REDIRECT;
        end
      end

      WR_MSTATUS_RET: begin
        stall_o           = 1'b1;
        clint_csr_wen_o   = ~cpu_csr_wen_i;
        clint_csr_waddr_o = ADDR_MSTATUS;
        clint_csr_wdata_o = ret_mstatus;
        if (!cpu_csr_wen_i) begin
          state_d = REDIRECT;
        end
      end

      REDIRECT: begin
        stall_o          = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = is_mret_q ? mepc_q : trap_target;
        state_d          = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// tb_clint_trap_ctrl: directed bench for the trap/interrupt sequencer.
// Inputs change just after a rising edge and outputs are sampled on the falling edge.
// Every cycle of each sequence is compared against hand-computed values.
module tb_clint_trap_ctrl;

  logic        clk;
  logic        rst;
  logic        inst_valid_i;
  logic [63:0] inst_pc_i;
  logic        ecall_i;
  logic        mret_i;
  logic        cpu_csr_wen_i;
  logic [63:0] csr_mtvec_i;
  logic [63:0] csr_mepc_i;
  logic [63:0] csr_mstatus_i;
  logic        global_int_en_i;
  logic        mtime_int_en_i;
  logic        mtime_int_pend_i;
  logic        clint_csr_wen_o;
  logic [11:0] clint_csr_waddr_o;
  logic [63:0] clint_csr_wdata_o;
  logic        stall_o;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;

  int errors = 0;
  int checks = 0;

  clint_trap_ctrl #(
    .ECALL_CAUSE(11),
    .MTI_CAUSE  (7),
    .VECTOR_EN  (1'b1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .inst_valid_i     (inst_valid_i),
    .inst_pc_i        (inst_pc_i),
    .ecall_i          (ecall_i),
    .mret_i           (mret_i),
    .cpu_csr_wen_i    (cpu_csr_wen_i),
    .csr_mtvec_i      (csr_mtvec_i),
    .csr_mepc_i       (csr_mepc_i),
    .csr_mstatus_i    (csr_mstatus_i),
    .global_int_en_i  (global_int_en_i),
    .mtime_int_en_i   (mtime_int_en_i),
    .mtime_int_pend_i (mtime_int_pend_i),
    .clint_csr_wen_o  (clint_csr_wen_o),
    .clint_csr_waddr_o(clint_csr_waddr_o),
    .clint_csr_wdata_o(clint_csr_wdata_o),
    .stall_o          (stall_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [63:0] pc, input logic ecall,
                               input logic mret, input logic cpu_wen, input logic [63:0] mtvec,
                               input logic [63:0] mepc, input logic [63:0] mstatus,
                               input logic gie, input logic mtie, input logic mtip);
    inst_valid_i     = valid;
    inst_pc_i        = pc;
    ecall_i          = ecall;
    mret_i           = mret;
    cpu_csr_wen_i    = cpu_wen;
    csr_mtvec_i      = mtvec;
    csr_mepc_i       = mepc;
    csr_mstatus_i    = mstatus;
    global_int_en_i  = gie;
    mtime_int_en_i   = mtie;
    mtime_int_pend_i = mtip;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Waits for the falling edge, then compares every output of the block.
  task automatic checkAll(input string tag, input logic wen, input logic [11:0] waddr,
                          input logic [63:0] wdata, input logic stall, input logic rv,
                          input logic [63:0] rpc);
    @(negedge clk);
    checkOutput({tag, ".wen"},   64'(clint_csr_wen_o),   64'(wen));
    checkOutput({tag, ".waddr"}, 64'(clint_csr_waddr_o), 64'(waddr));
    checkOutput({tag, ".wdata"}, clint_csr_wdata_o,      wdata);
    checkOutput({tag, ".stall"}, 64'(stall_o),           64'(stall));
    checkOutput({tag, ".rv"},    64'(redirect_valid_o),  64'(rv));
    checkOutput({tag, ".rpc"},   redirect_pc_o,          rpc);
  endtask

  // Directed sequence of scenarios, each one ending back in IDLE.
  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    checkAll("reset_held", 1'b0, 12'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    rst = 1'b0;
    checkAll("reset_idle", 1'b0, 12'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    nextCycle();

    // Timer interrupt, direct mtvec.
    applyStimulus(1'b1, 64'h8000_0100, 1'b0, 1'b0, 1'b0, 64'h8000_0000, 64'h0, 64'h1888, 1'b1, 1'b1, 1'b1);
    checkAll("int_accept", 1'b0, 12'h0, 64'h0, 1'b1, 1'b0, 64'h0);
    nextCycle();
    checkAll("int_mepc", 1'b1, 12'h341, 64'h8000_0100, 1'b1, 1'b0, 64'h0);
    nextCycle();
    checkAll("int_mcause", 1'b1, 12'h342, 64'h8000_0000_0000_0007, 1'b1, 1'b0, 64'h0);
    nextCycle();
    checkAll("int_mstatus", 1'b1, 12'h300, 64'h1880, 1'b1, 1'b0, 64'h0);
    nextCycle();
    inst_valid_i = 1'b0;
    checkAll("int_redirect", 1'b0, 12'h0, 64'h0, 1'b1, 1'b1, 64'h8000_0000);
    nextCycle();
    checkAll("int_done", 1'b0, 12'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    nextCycle();

    // ecall with vectored mtvec and interrupts disabled; exceptions use the base.
    applyStimulus(1'b1, 64'h8000_0200, 1'b1, 1'b0, 1'b0, 64'h8000_0001, 64'h0, 64'h0080, 1'b0, 1'b1, 1'b1);
    checkAll("ecall_accept", 1'b0, 12'h0, 64'h0, 1'b1, 1'b0, 64'h0);
    nextCycle();
    checkAll("ecall_mepc", 1'b1, 12'h341, 64'h8000_0200, 1'b1, 1'b0, 64'h0);
    nextCycle();
    checkAll("ecall_mcause", 1'b1, 12'h342, 64'd11, 1'b1, 1'b0, 64'h0);
    nextCycle();
    checkAll("ecall_mstatus", 1'b1, 12'h300, 64'h1800, 1'b1, 1'b0, 64'h0);
    nextCycle();
    inst_valid_i = 1'b0;
    checkAll("ecall_redirect", 1'b0, 12'h0, 64'h0, 1'b1, 1'b1, 64'h8000_0000);
    nextCycle();

    // Vectored timer interrupt lands at base + 7*4.
    applyStimulus(1'b1, 64'h8000_0300, 1'b0, 1'b0, 1'b0, 64'h8000_0001, 64'h0, 64'h1888, 1'b1, 1'b1, 1'b1);
    checkAll("vec_accept", 1'b0, 12'h0, 64'h0, 1'b1, 1'b0, 64'h0);
    nextCycle();
    checkAll("vec_mepc", 1'b1, 12'h341, 64'h8000_0300, 1'b1, 1'b0, 64'h0);
    nextCycle();
    checkAll("vec_mcause", 1'b1, 12'h342, 64'h8000_0000_0000_0007, 1'b1, 1'b0, 64'h0);
    nextCycle();
    checkAll("vec_mstatus", 1'b1, 12'h300, 64'h1880, 1'b1, 1'b0, 64'h0);
    nextCycle();
    inst_valid_i = 1'b0;
    checkAll("vec_redirect", 1'b0, 12'h0, 64'h0, 1'b1, 1'b1, 64'h8000_001C);
    nextCycle();

    // mret restores MIE from MPIE and returns to mepc.
    applyStimulus(1'b1, 64'h8000_0040, 1'b0, 1'b1, 1'b0, 64'h8000_0000, 64'h8000_0104, 64'h1880, 1'b0, 1'b1, 1'b0);
    checkAll("mret_accept", 1'b0, 12'h0, 64'h0, 1'b1, 1'b0, 64'h0);
    nextCycle();
    checkAll("mret_mstatus", 1'b1, 12'h300, 64'h1888, 1'b1, 1'b0, 64'h0);
    nextCycle();
    inst_valid_i = 1'b0;
    checkAll("mret_redirect", 1'b0, 12'h0, 64'h0, 1'b1, 1'b1, 64'h8000_0104);
    nextCycle();
    checkAll("mret_done", 1'b0, 12'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    nextCycle();

    // CPU CSR write holds off the mcause write for two cycles.
    applyStimulus(1'b1, 64'h8000_0400, 1'b0, 1'b0, 1'b0, 64'h8000_0000, 64'h0, 64'h1888, 1'b1, 1'b1, 1'b1);
    checkAll("cfl_accept", 1'b0, 12'h0, 64'h0, 1'b1, 1'b0, 64'h0);
    nextCycle();
    checkAll("cfl_mepc", 1'b1, 12'h341, 64'h8000_0400, 1'b1, 1'b0, 64'h0);
    nextCycle();
    cpu_csr_wen_i = 1'b1;
    checkAll("cfl_hold1", 1'b0, 12'h342, 64'h8000_0000_0000_0007, 1'b1, 1'b0, 64'h0);
    nextCycle();
    checkAll("cfl_hold2", 1'b0, 12'h342, 64'h8000_0000_0000_0007, 1'b1, 1'b0, 64'h0);
    nextCycle();
    cpu_csr_wen_i = 1'b0;
    checkAll("cfl_mcause", 1'b1, 12'h342, 64'h8000_0000_0000_0007, 1'b1, 1'b0, 64'h0);
    nextCycle();
    checkAll("cfl_mstatus", 1'b1, 12'h300, 64'h1880, 1'b1, 1'b0, 64'h0);
    nextCycle();
    inst_valid_i = 1'b0;
    checkAll("cfl_redirect", 1'b0, 12'h0, 64'h0, 1'b1, 1'b1, 64'h8000_0000);
    nextCycle();

    // Reset in WR_MCAUSE aborts without a redirect.
    applyStimulus(1'b1, 64'h8000_0500, 1'b0, 1'b0, 1'b0, 64'h8000_0000, 64'h0, 64'h1888, 1'b1, 1'b1, 1'b1);
    checkAll("rst_accept", 1'b0, 12'h0, 64'h0, 1'b1, 1'b0, 64'h0);
    nextCycle();
    checkAll("rst_mepc", 1'b1, 12'h341, 64'h8000_0500, 1'b1, 1'b0, 64'h0);
    nextCycle();
    rst = 1'b1;
    inst_valid_i = 1'b0;
    nextCycle();
    rst = 1'b0;
    checkAll("rst_abort", 1'b0, 12'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    nextCycle();
    checkAll("rst_noredir", 1'b0, 12'h0, 64'h0, 1'b0, 1'b0, 64'h0);
    nextCycle();

    // Interrupt and ecall together after the abort: the interrupt sequence wins.
    applyStimulus(1'b1, 64'h8000_0600, 1'b1, 1'b0, 1'b0, 64'h8000_0000, 64'h0, 64'h1888, 1'b1, 1'b1, 1'b1);
    checkAll("both_accept", 1'b0, 12'h0, 64'h0, 1'b1, 1'b0, 64'h0);
    nextCycle();
    checkAll("both_mepc", 1'b1, 12'h341, 64'h8000_0600, 1'b1, 1'b0, 64'h0);
    nextCycle();
    checkAll("both_mcause", 1'b1, 12'h342, 64'h8000_0000_0000_0007, 1'b1, 1'b0, 64'h0);
    nextCycle();
    checkAll("both_mstatus", 1'b1, 12'h300, 64'h1880, 1'b1, 1'b0, 64'h0);
    nextCycle();
    inst_valid_i = 1'b0;
    checkAll("both_redirect", 1'b0, 12'h0, 64'h0, 1'b1, 1'b1, 64'h8000_0000);
    nextCycle();
    checkAll("both_done", 1'b0, 12'h0, 64'h0, 1'b0, 1'b0, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
